// File: rtl/chip8_scanout.sv
// Streams a captured 64x32 CHIP-8 framebuffer out as 256 packed pixel bytes
// over a valid/ready link. Define CHIP8_SCANOUT_CKSUM_EN to append an XOR checksum byte.
module chip8_scanout #(
    parameter bit INVERT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [2047:0] display,
    input  logic          start,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done
);

`ifdef CHIP8_SCANOUT_CKSUM_EN
    localparam logic [8:0] LAST_IDX = 9'd256;
`else
    localparam logic [8:0] LAST_IDX = 9'd255;
`endif

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t        state_q, state_d;
    logic [2047:0] shadow_q, shadow_d;
    logic [8:0]    idx_q, idx_d;
    logic [7:0]    raw_byte;
    logic [7:0]    pix_byte;
    logic [7:0]    byte_out;
    logic          xfer;

    // Byte k covers shadow bits k*8..k*8+7; the lowest bit is the leftmost pixel.
    always_comb begin
        raw_byte = shadow_q[{idx_q[7:0], 3'b000} +: 8];
        for (int i = 0; i < 8; i++) begin
            pix_byte[7-i] = raw_byte[i] ^ INVERT;
        end
    end

`ifdef CHIP8_SCANOUT_CKSUM_EN
    logic [7:0] cksum_q, cksum_d;

    always_comb begin
        cksum_d = cksum_q;
        if (state_q == IDLE && start) begin
            cksum_d = 8'h00;
        end else if (xfer && !idx_q[8]) begin
            cksum_d = cksum_q ^ pix_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cksum_q <= 8'h00;
        end else begin
            cksum_q <= cksum_d;
        end
    end

    assign byte_out = idx_q[8] ? cksum_q : pix_byte;
`else
    assign byte_out = pix_byte;
`endif

    assign xfer       = (state_q == SEND) && out_ready;
    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);
    assign out_data   = out_valid ? byte_out : 8'h00;
    assign out_first  = out_valid && (idx_q == 9'd0);
    assign out_last   = out_valid && (idx_q == LAST_IDX);

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = display;
                    idx_d    = 9'd0;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 9'd0;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 9'd1;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            idx_q    <= 9'd0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_chip8_scanout.sv
// Scoreboard bench for chip8_scanout: two instances (INVERT=0/1) share stimulus;
// expected frames are computed from pixel coordinates when a start is accepted.
module tb_chip8_scanout;

`ifdef CHIP8_SCANOUT_CKSUM_EN
    localparam int NB = 257;
`else
    localparam int NB = 256;
`endif

    typedef struct {
        logic [7:0] d;
        logic       f;
        logic       l;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, start, out_ready;
    logic [2047:0] display;
    logic          out_valid [2];
    logic [7:0]    out_data  [2];
    logic          out_first [2];
    logic          out_last  [2];
    logic          busy      [2];
    logic          frame_done[2];

    int   checks = 0;
    int   failures = 0;
    exp_t exp_q[2][$];
    int   m_mode = 0;    // 0 idle, 1 sending, 2 done
    int   m_cnt = 0;
    int   m_frames = 0;

    always #5 clk = ~clk;

    chip8_scanout #(.INVERT(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .display(display), .start(start), .out_ready(out_ready),
        .out_valid(out_valid[0]), .out_data(out_data[0]), .out_first(out_first[0]),
        .out_last(out_last[0]), .busy(busy[0]), .frame_done(frame_done[0]));

    chip8_scanout #(.INVERT(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .display(display), .start(start), .out_ready(out_ready),
        .out_valid(out_valid[1]), .out_data(out_data[1]), .out_first(out_first[1]),
        .out_last(out_last[1]), .busy(busy[1]), .frame_done(frame_done[1]));

    task automatic chk(input string nm, input int u, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s inst=%0d t=%0t got=%h exp=%h", nm, u, $time, got, exp);
        end
    endtask

    // Reference model: frame-level behaviour, expected bytes built from (x,y) pixel lookups.
    always @(posedge clk) begin
        if (reset) begin
            m_mode = 0;
            m_cnt  = 0;
            for (int u = 0; u < 2; u++) exp_q[u].delete();
        end else begin
            case (m_mode)
                0: if (start) begin
                    for (int u = 0; u < 2; u++) begin
                        logic [7:0] cs;
                        cs = 8'h00;
                        for (int k = 0; k < 256; k++) begin
                            exp_t e;
                            logic [7:0] b;
                            b = 8'h00;
                            for (int j = 0; j < 8; j++) begin
                                int x, y;
                                x = (k % 8) * 8 + j;
                                y = k / 8;
                                b[7-j] = display[y*64 + x] ^ (u == 1);
                            end
                            e.d = b; e.f = (k == 0); e.l = (k == NB - 1);
                            exp_q[u].push_back(e);
                            cs ^= b;
                        end
                        if (NB == 257) begin
                            exp_t e;
                            e.d = cs; e.f = 1'b0; e.l = 1'b1;
                            exp_q[u].push_back(e);
                        end
                    end
                    m_cnt  = 0;
                    m_mode = 1;
                end
                1: if (out_ready) begin
                    m_cnt++;
                    if (m_cnt == NB) begin
                        m_mode = 2;
                        m_frames++;
                    end
                end
                default: m_mode = 0;
            endcase
        end
    end

    // Monitor: compare outputs against model state and scoreboard head.
    always @(negedge clk) begin
        for (int u = 0; u < 2; u++) begin
            chk("out_valid", u, 32'(out_valid[u]), 32'(m_mode == 1));
            chk("busy", u, 32'(busy[u]), 32'(m_mode != 0));
            chk("frame_done", u, 32'(frame_done[u]), 32'(m_mode == 2));
            if (m_mode == 1) begin
                if (exp_q[u].size() == 0) begin
                    chk("queue_underflow", u, 32'd1, 32'd0);
                end else begin
                    chk("out_data", u, 32'(out_data[u]), 32'(exp_q[u][0].d));
                    chk("out_first", u, 32'(out_first[u]), 32'(exp_q[u][0].f));
                    chk("out_last", u, 32'(out_last[u]), 32'(exp_q[u][0].l));
                    if (out_ready) void'(exp_q[u].pop_front());
                end
            end else begin
                chk("idle_data", u, 32'(out_data[u]), 32'd0);
                chk("idle_first", u, 32'(out_first[u]), 32'd0);
                chk("idle_last", u, 32'(out_last[u]), 32'd0);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_mode != 0 && n < 3000) begin
            cyc();
            n++;
        end
        chk("idle_timeout", 0, 32'(n >= 3000), 32'd0);
    endtask

    task automatic rand_display();
        for (int w = 0; w < 64; w++) display[w*32 +: 32] = $urandom;
    endtask

    // rmode: 0 ready=1, 1 ready 1,0,0,1 + mid-frame start pulses,
    //        2 random ready + display flip after byte 10, 3 reset at byte 100
    task automatic run_frame(input int rmode);
        int n = 0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        while (m_mode != 0 && n < 3000) begin
            case (rmode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = (n % 4 == 0) || (n % 4 == 3);
                    start     = (n % 37 == 5);
                end
                2: begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    if (m_cnt >= 10) display = '1;
                end
                default: begin
                    out_ready = 1'b1;
                    if (m_cnt == 100) reset = 1'b1;
                end
            endcase
            cyc();
            reset = 1'b0;
            n++;
        end
        start = 1'b0;
        chk("frame_timeout", 0, 32'(n >= 3000), 32'd0);
    endtask

    initial begin
        int f0;
        reset = 1'b1; start = 1'b0; out_ready = 1'b0; display = '0;
        repeat (3) cyc();
        reset = 1'b0;
        cyc();

        display = '0; display[0] = 1'b1;
        run_frame(0);
        cyc();
        display = '0; display[2047] = 1'b1;
        run_frame(0);
        cyc();

        rand_display();
        run_frame(1);
        cyc();
        rand_display();
        run_frame(2);
        cyc();

        rand_display();
        f0 = m_frames;
        run_frame(3);
        chk("no_done_after_reset", 0, 32'(m_frames), 32'(f0));
        cyc();
        rand_display();
        run_frame(0);
        cyc();

        // start held high: back-to-back frames
        rand_display();
        f0 = m_frames;
        start = 1'b1;
        for (int n = 0; n < 5000 && m_frames < f0 + 3; n++) begin
            out_ready = ($urandom_range(0, 4) != 0);
            if (m_cnt == 50) rand_display();
            cyc();
        end
        start = 1'b0;
        chk("held_frames", 0, 32'(m_frames), 32'(f0 + 3));
        wait_idle();
        out_ready = 1'b1;
        repeat (3) cyc();

        for (int u = 0; u < 2; u++) chk("queue_empty", u, 32'(exp_q[u].size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
